// File: rtl/saturating_drain_pkg.sv
// Shared types and constants for the saturating drain block: state encoding,
// output word field offsets and the default operand width.
package saturating_drain_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offsets inside the packed {acc, busy, done, at_floor} output word
    localparam int OUT_AT_FLOOR = 0;
    localparam int OUT_DONE     = 1;
    localparam int OUT_BUSY     = 2;
    localparam int OUT_ACC      = 3;

endpackage

// File: rtl/saturating_sub_floor.sv
// Combinational a - step, clamped so the result never borrows below zero and
// never drops under floor.
module saturating_sub_floor
    import saturating_drain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] floor,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH:0] diff;

    always_comb begin
        // Extra MSB catches the borrow when step exceeds a
        diff = {1'b0, a} - {1'b0, step};
        if (diff[WIDTH] || (diff[WIDTH-1:0] < floor))
            result = floor;
        else
            result = diff[WIDTH-1:0];
    end

endmodule

// File: rtl/saturating_drain.sv
// Drains an accumulator by a fixed step each cycle down to a latched floor,
// then pulses done for one cycle and returns to idle holding the final value.
module saturating_drain
    import saturating_drain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             _m_clk,
    input  logic             _m_rst,
    input  logic             _m_start,
    input  logic [WIDTH-1:0] _m_value,
    input  logic [WIDTH-1:0] _m_step,
    input  logic [WIDTH-1:0] _m_min,
    output logic [WIDTH+2:0] __output
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] floor_q, floor_d;

    logic [WIDTH-1:0] sub_a, sub_step, sub_floor, sub_res;

    // In IDLE a zero step turns the subtractor into max(value, min) for the load
    always_comb begin
        if (state_q == IDLE) begin
            sub_a     = _m_value;
            sub_step  = '0;
            sub_floor = _m_min;
        end else begin
            sub_a     = acc_q;
            sub_step  = step_q;
            sub_floor = floor_q;
        end
    end

    saturating_sub_floor #(.WIDTH(WIDTH)) u_sub (
        .a      (sub_a),
        .step   (sub_step),
        .floor  (sub_floor),
        .result (sub_res)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        floor_d = floor_q;
        case (state_q)
            IDLE: begin
                if (_m_start) begin
                    step_d  = _m_step;
                    floor_d = _m_min;
                    acc_d   = sub_res;
                    state_d = ((_m_value <= _m_min) || (_m_step == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                acc_d = sub_res;
                if (sub_res == floor_q)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge _m_clk) begin
        if (_m_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            floor_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            floor_q <= floor_d;
        end
    end

    always_comb begin
        __output                     = '0;
        __output[OUT_ACC +: WIDTH]   = acc_q;
        __output[OUT_BUSY]           = (state_q != IDLE);
        __output[OUT_DONE]           = (state_q == DONE);
        __output[OUT_AT_FLOOR]       = (acc_q == floor_q);
    end

endmodule

// File: tb/tb_saturating_drain.sv
// Self-checking bench for saturating_drain: directed scenarios plus random jobs
// compared cycle by cycle against an arithmetic trace model.
module tb_saturating_drain;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] value, step, mn;
    logic [W+2:0] dout;

    int vectors = 0;
    int errors  = 0;

    // Model: expected output words for each cycle of the current job
    logic [W+2:0] exp_q[$];
    int           m_acc, m_floor;

    saturating_drain #(.WIDTH(W)) dut (
        ._m_clk   (clk),
        ._m_rst   (rst),
        ._m_start (start),
        ._m_value (value),
        ._m_step  (step),
        ._m_min   (mn),
        .__output (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [W+2:0] pack(input int a, input int f, input bit busy, input bit done);
        logic [W-1:0] av;
        av = W'(a);
        return {av, busy, done, (a == f)};
    endfunction

    task automatic build_trace(input int v, input int s, input int f);
        int a;
        exp_q.delete();
        m_floor = f;
        a = (v > f) ? v : f;
        if (v <= f || s == 0) begin
            exp_q.push_back(pack(a, f, 1'b1, 1'b1));
        end else begin
            exp_q.push_back(pack(a, f, 1'b1, 1'b0));
            while (a != f) begin
                a = (a - s > f) ? a - s : f;
                exp_q.push_back(pack(a, f, 1'b1, a == f));
            end
        end
        m_acc = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int v, input int s, input int f);
        value = W'(v);
        step  = W'(s);
        mn    = W'(f);
        start = 1'b1;
        build_trace(v, s, f);
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; value = 8'd77; step = 8'd1; mn = 8'd0;
        tick(); tick();
        rst = 1'b0; start = 1'b0;
        m_acc = 0; m_floor = 0;
        vectors++;
        // acc == floor == 0 after reset, so at_floor is the only bit set
        if (dout !== pack(0, 0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dout, pack(0, 0, 1'b0, 1'b0));
        end
        tick();
        vectors++;
        if (dout !== pack(0, 0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_idle_hold: got %h want %h", dout, pack(0, 0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_nominal();
        launch(10, 3, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            vectors++;
            if (dout !== exp_q[i]) begin
                errors++;
                $display("FAIL nominal_cyc%0d: got %h want %h", i, dout, exp_q[i]);
            end
        end
        tick();
        vectors++;
        if (dout !== pack(m_acc, m_floor, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL nominal_idle: got %h want %h", dout, pack(m_acc, m_floor, 1'b0, 1'b0));
        end
    endtask

    task automatic test_underflow();
        launch(5, 200, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            vectors++;
            if (dout !== exp_q[i]) begin
                errors++;
                $display("FAIL underflow_cyc%0d: got %h want %h", i, dout, exp_q[i]);
            end
        end
        tick();
        vectors++;
        if (dout !== pack(0, 0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL underflow_idle: got %h want %h", dout, pack(0, 0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_floor_immediate();
        launch(3, 1, 5);
        vectors++;
        if (dout !== pack(5, 5, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL floor_imm_done: got %h want %h", dout, pack(5, 5, 1'b1, 1'b1));
        end
        // A start presented during DONE must be dropped
        start = 1'b1; value = 8'd50; step = 8'd1; mn = 8'd0;
        tick();
        start = 1'b0;
        vectors++;
        if (dout !== pack(5, 5, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL start_in_done: got %h want %h", dout, pack(5, 5, 1'b0, 1'b0));
        end
        tick();
        vectors++;
        if (dout !== pack(5, 5, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL floor_imm_hold: got %h want %h", dout, pack(5, 5, 1'b0, 1'b0));
        end
        m_acc = 5; m_floor = 5;
    endtask

    task automatic test_zero_step();
        launch(9, 0, 1);
        vectors++;
        if (dout !== pack(9, 1, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL zero_step_done: got %h want %h", dout, pack(9, 1, 1'b1, 1'b1));
        end
        tick();
        vectors++;
        if (dout !== pack(9, 1, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL zero_step_idle: got %h want %h", dout, pack(9, 1, 1'b0, 1'b0));
        end
    endtask

    task automatic test_start_during_job();
        launch(20, 1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            vectors++;
            if (dout !== exp_q[i]) begin
                errors++;
                $display("FAIL busy_start_cyc%0d: got %h want %h", i, dout, exp_q[i]);
            end
            start = (i == 3);
            if (i == 3) begin value = 8'd99; step = 8'd5; mn = 8'd7; end
        end
        start = 1'b0;
        tick();
        vectors++;
        if (dout !== pack(0, 0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL busy_start_idle: got %h want %h", dout, pack(0, 0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_mid_run();
        launch(20, 1, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (dout !== pack(0, 0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL mid_run_reset: got %h want %h", dout, pack(0, 0, 1'b0, 1'b0));
        end
        launch(4, 2, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            vectors++;
            if (dout !== exp_q[i]) begin
                errors++;
                $display("FAIL post_reset_cyc%0d: got %h want %h", i, dout, exp_q[i]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        int v, s, f, lat_seen, lat_exp;
        for (int j = 0; j < 40; j++) begin
            v = int'($urandom_range(0, 255));
            f = int'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            lat_exp = (v > f && s > 0) ? (v - f + s - 1) / s + 1 : 1;
            lat_seen = 0;
            launch(v, s, f);
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) tick();
                vectors++;
                if (dout !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_job%0d_cyc%0d: got %h want %h (v=%0d s=%0d f=%0d)", j, i, dout, exp_q[i], v, s, f);
                end
                if (dout[1] === 1'b1 && lat_seen == 0) lat_seen = i + 1;
                // Junk on every input while busy must not disturb the job
                start = 1'($urandom);
                value = W'($urandom);
                step  = W'($urandom);
                mn    = W'($urandom);
            end
            start = 1'b0;
            vectors++;
            if (lat_seen != lat_exp) begin
                errors++;
                $display("FAIL rand_latency%0d: got %0d want %0d", j, lat_seen, lat_exp);
            end
            tick();
            vectors++;
            if (dout !== pack(m_acc, m_floor, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL rand_idle%0d: got %h want %h", j, dout, pack(m_acc, m_floor, 1'b0, 1'b0));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; value = '0; step = '0; mn = '0;
        test_reset();
        test_nominal();
        test_underflow();
        test_floor_immediate();
        test_zero_step();
        test_start_during_job();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
